// File: rtl/uart_dump_pkg.sv
// rtl/uart_dump_pkg.sv - shared states, frame constants and baud divider for the UART memory dumper
package uart_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } state_e;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   BITS_PER_FRAME = 10;
  localparam int   BYTES_PER_WORD = 4;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_mem_dump_if.sv
// rtl/uart_mem_dump_if.sv - request, RAM read port and serial output bundle of the memory dumper
interface uart_mem_dump_if #(
  parameter int ADR_W = 14
);
  logic             start;
  logic [ADR_W-1:0] base_addr;
  logic [ADR_W:0]   word_count;
  logic [ADR_W-1:0] mem_adr;
  logic             mem_ren;
  logic [31:0]      mem_dat;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (
    output start, base_addr, word_count, mem_dat,
    input  mem_adr, mem_ren, tx, busy, done
  );

  modport slave (
    input  start, base_addr, word_count, mem_dat,
    output mem_adr, mem_ren, tx, busy, done
  );
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte transmitter; ready rises in the last stop-bit cycle so bytes chain gap-free
module uart_tx_byte
  import uart_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 78
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic                      active_q, active_d;
  logic [BITS_PER_FRAME-1:0] shift_q, shift_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]          baud_cnt_q, baud_cnt_d;
  logic                      baud_end, frame_end;

  assign baud_end  = active_q && (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign frame_end = baud_end && (bit_cnt_q == 4'(BITS_PER_FRAME - 1));
  assign ready_o   = !active_q || frame_end;
  assign tx_o      = active_q ? shift_q[0] : STOP_BIT;

  always_comb begin
    active_d   = active_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    if (active_q) begin
      if (baud_end) begin
        baud_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 4'd1;
        shift_d    = {STOP_BIT, shift_q[BITS_PER_FRAME-1:1]};
        if (frame_end) active_d = 1'b0;
      end else begin
        baud_cnt_d = baud_cnt_q + CNT_W'(1);
      end
    end
    if (valid_i && ready_o) begin
      active_d   = 1'b1;
      shift_d    = {STOP_BIT, data_i, START_BIT};
      bit_cnt_d  = '0;
      baud_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
    end else begin
      active_q   <= active_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
    end
  end
endmodule

// File: rtl/uart_mem_dump.sv
// rtl/uart_mem_dump.sv - streams a range of 32-bit RAM words out of a UART, LSB byte first
// Optional trailing XOR checksum byte with UART_DUMP_CHECKSUM_EN defined.
module uart_mem_dump
  import uart_dump_pkg::*;
#(
  parameter int CLK_HZ = 10000000,
  parameter int BAUD   = 128000,
  parameter int ADR_W  = 14
) (
  input logic            clk,
  input logic            rst,
  uart_mem_dump_if.slave bus
);
  localparam int             CPB      = clks_per_bit(CLK_HZ, BAUD);
  localparam logic [2:0]     LAST_IDX = 3'(BYTES_PER_WORD - 1);
  localparam logic [ADR_W-1:0] ADR_ONE = ADR_W'(1);
  localparam logic [ADR_W:0]   CNT_ONE = (ADR_W+1)'(1);

  state_e           state_q, state_d;
  logic [ADR_W-1:0] next_adr_q, next_adr_d;
  logic [ADR_W-1:0] last_adr_q, last_adr_d;
  logic [ADR_W:0]   words_left_q, words_left_d;
  logic [23:0]      upper_q, upper_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic             tx_valid, tx_ready, ren;
  logic [7:0]       tx_data;
  logic [ADR_W-1:0] adr;
`ifdef UART_DUMP_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  uart_tx_byte #(.CLKS_PER_BIT(CPB)) u_tx (
    .clk    (clk),
    .rst    (rst),
    .data_i (tx_data),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .tx_o   (bus.tx)
  );

  assign bus.mem_ren = ren;
  assign bus.mem_adr = adr;
  assign bus.busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign bus.done    = (state_q == ST_FIN);

  always_comb begin
    state_d      = state_q;
    next_adr_d   = next_adr_q;
    last_adr_d   = last_adr_q;
    words_left_d = words_left_q;
    upper_d      = upper_q;
    byte_idx_d   = byte_idx_q;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    ren          = 1'b0;
    adr          = last_adr_q;
`ifdef UART_DUMP_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      ST_IDLE: if (bus.start) begin
        next_adr_d   = bus.base_addr;
        words_left_d = bus.word_count;
`ifdef UART_DUMP_CHECKSUM_EN
        chk_d        = 8'h00;
        if (bus.word_count == '0) begin
          tx_valid   = 1'b1;
          byte_idx_d = 3'd4;
          state_d    = ST_SEND;
        end else state_d = ST_FETCH;
`else
        state_d = (bus.word_count == '0) ? ST_FIN : ST_FETCH;
`endif
      end
      ST_FETCH: begin
        ren          = 1'b1;
        adr          = next_adr_q;
        last_adr_d   = next_adr_q;
        next_adr_d   = next_adr_q + ADR_ONE;
        words_left_d = words_left_q - CNT_ONE;
        state_d      = ST_WAIT;
      end
      // Byte 0 is loaded straight from the RAM so tx falls on the first SEND cycle.
      ST_WAIT: begin
        upper_d    = bus.mem_dat[31:8];
        tx_valid   = 1'b1;
        tx_data    = bus.mem_dat[7:0];
        byte_idx_d = 3'd0;
        state_d    = ST_SEND;
`ifdef UART_DUMP_CHECKSUM_EN
        chk_d      = chk_q ^ bus.mem_dat[7:0];
`endif
      end
      ST_SEND: if (tx_ready) begin
        if (byte_idx_q < LAST_IDX) begin
          tx_valid = 1'b1;
          case (byte_idx_q)
            3'd0:    tx_data = upper_q[7:0];
            3'd1:    tx_data = upper_q[15:8];
            default: tx_data = upper_q[23:16];
          endcase
          byte_idx_d = byte_idx_q + 3'd1;
`ifdef UART_DUMP_CHECKSUM_EN
          chk_d      = chk_q ^ tx_data;
`endif
        end else if (byte_idx_q == LAST_IDX && words_left_q != '0) begin
          state_d = ST_FETCH;
`ifdef UART_DUMP_CHECKSUM_EN
        end else if (byte_idx_q == LAST_IDX) begin
          tx_valid   = 1'b1;
          tx_data    = chk_q;
          byte_idx_d = 3'd4;
`endif
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_adr_q   <= '0;
      last_adr_q   <= '0;
      words_left_q <= '0;
      upper_q      <= '0;
      byte_idx_q   <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      next_adr_q   <= next_adr_d;
      last_adr_q   <= last_adr_d;
      words_left_q <= words_left_d;
      upper_q      <= upper_d;
      byte_idx_q   <= byte_idx_d;
`ifdef UART_DUMP_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_mem_dump.sv
// tb/tb_uart_mem_dump.sv - randomized bench with serial decoder and word-level dump model
module tb_uart_mem_dump;
  localparam int CLK_HZ   = 10000000;
  localparam int BAUD     = 128000;
  localparam int ADR_W    = 14;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int WORD_CYC = 4 * BYTE_CYC;
  localparam int PERIOD   = WORD_CYC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_mem_dump_if #(.ADR_W(ADR_W)) bus();
  uart_mem_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADR_W(ADR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<ADR_W)-1];
  always @(posedge clk) if (bus.mem_ren) bus.mem_dat <= mem[bus.mem_adr];

  int n_checks = 0, n_fail = 0;
  logic tx_q[$], busy_q[$];
  int ren_cyc_q[$], got_pos[$], exp_pos[$], exp_ren[$];
  logic [ADR_W-1:0] ren_adr_q[$], exp_adr[$];
  logic [7:0] got_b[$], exp_b[$];
  int done_cyc, done_n, exp_done, hold_err;

  task automatic run_dump(input logic [ADR_W-1:0] base, input logic [ADR_W:0] cnt,
                          input int restart_at, input int rst_at, input int limit);
    tx_q.delete(); busy_q.delete(); ren_cyc_q.delete(); ren_adr_q.delete();
    done_cyc = -1; done_n = 0;
    @(negedge clk);
    bus.base_addr = base; bus.word_count = cnt; bus.start = 1'b1;
    tx_q.push_back(bus.tx); busy_q.push_back(bus.busy);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      tx_q.push_back(bus.tx); busy_q.push_back(bus.busy);
      if (bus.mem_ren) begin ren_cyc_q.push_back(c); ren_adr_q.push_back(bus.mem_adr); end
      if (bus.done) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      bus.start = (c == restart_at);
      if (c == restart_at) begin bus.base_addr = base ^ 14'h0155; bus.word_count = cnt + 15'd3; end
      rst = (c == rst_at);
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    bus.start = 1'b0; rst = 1'b0;
  endtask

  // Frame decoder: every bit must hold for CPB cycles and end with a stop bit of 1.
  task automatic decode();
    int i;
    logic [9:0] fr;
    got_b.delete(); got_pos.delete(); hold_err = 0; i = 0;
    while (i < tx_q.size()) begin
      if (tx_q[i] === 1'b0) begin
        if (i + BYTE_CYC > tx_q.size()) begin hold_err++; break; end
        for (int b = 0; b < 10; b++) begin
          fr[b] = tx_q[i + b*CPB];
          for (int k = 1; k < CPB; k++) if (tx_q[i + b*CPB + k] !== fr[b]) hold_err++;
        end
        if (fr[9] !== 1'b1) hold_err++;
        got_b.push_back(fr[8:1]); got_pos.push_back(i);
        i += BYTE_CYC;
      end else i++;
    end
  endtask

  task automatic model(input logic [ADR_W-1:0] base, input int cnt);
    logic [7:0] chk, b;
    logic [ADR_W-1:0] a;
    exp_b.delete(); exp_pos.delete(); exp_ren.delete(); exp_adr.delete(); chk = 8'h00;
    for (int i = 0; i < cnt; i++) begin
      a = ADR_W'((int'(base) + i) % (1 << ADR_W));
      exp_adr.push_back(a); exp_ren.push_back(1 + i*PERIOD);
      for (int j = 0; j < 4; j++) begin
        b = 8'((mem[a] >> (8*j)) & 32'hFF);
        exp_b.push_back(b); exp_pos.push_back(3 + i*PERIOD + j*BYTE_CYC); chk ^= b;
      end
    end
    exp_done = (cnt == 0) ? 1 : 3 + (cnt-1)*PERIOD + WORD_CYC;
`ifdef UART_DUMP_CHECKSUM_EN
    exp_b.push_back(chk); exp_pos.push_back(exp_done); exp_done += BYTE_CYC;
`endif
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0; rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b exp 1", bus.tx); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_checks++; if (bus.mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b exp 0", bus.mem_ren); end
    n_checks++; if (bus.mem_adr !== '0) begin n_fail++; $display("FAIL reset_adr got %h exp 0", bus.mem_adr); end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    mem[14'h0010] = 32'h12345678;
    model(14'h0010, 1);
    run_dump(14'h0010, 15'd1, -1, -1, exp_done + 20);
    decode();
    n_checks++; if (ren_cyc_q.size() != 1 || ren_cyc_q[0] != 1) begin n_fail++; $display("FAIL single_ren n=%0d first=%0d exp cycle 1", ren_cyc_q.size(), ren_cyc_q.size() ? ren_cyc_q[0] : -1); end
    n_checks++; if (ren_adr_q.size() != 1 || ren_adr_q[0] !== 14'h0010) begin n_fail++; $display("FAIL single_adr exp 0010"); end
    n_checks++; if (tx_q[3] !== 1'b0 || tx_q[2] !== 1'b1) begin n_fail++; $display("FAIL single_txlow c2=%b c3=%b exp 1,0", tx_q[2], tx_q[3]); end
    n_checks++; if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL single_nbytes got %0d exp %0d", got_b.size(), exp_b.size()); end
    for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
      n_checks++; if (got_b[k] !== exp_b[k] || got_pos[k] != exp_pos[k]) begin n_fail++; $display("FAIL single_byte%0d got %h@%0d exp %h@%0d", k, got_b[k], got_pos[k], exp_b[k], exp_pos[k]); end
    end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL single_framing got %0d errors exp 0", hold_err); end
    n_checks++; if (done_cyc != exp_done || done_n != 1) begin n_fail++; $display("FAIL single_done got %0d (x%0d) exp %0d", done_cyc, done_n, exp_done); end
  endtask

  task automatic test_zero_count();
    logic [ADR_W-1:0] base;
    int zeros;
    base = ADR_W'($urandom);
    model(base, 0);
    run_dump(base, 15'd0, -1, -1, exp_done + 20);
    decode();
    n_checks++; if (done_cyc != exp_done || done_n != 1) begin n_fail++; $display("FAIL zero_done got %0d (x%0d) exp %0d", done_cyc, done_n, exp_done); end
    n_checks++; if (ren_cyc_q.size() != 0) begin n_fail++; $display("FAIL zero_ren got %0d strobes exp 0", ren_cyc_q.size()); end
    n_checks++; if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL zero_nbytes got %0d exp %0d", got_b.size(), exp_b.size()); end
    for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
      n_checks++; if (got_b[k] !== exp_b[k]) begin n_fail++; $display("FAIL zero_chk got %h exp %h", got_b[k], exp_b[k]); end
    end
`ifndef UART_DUMP_CHECKSUM_EN
    zeros = 0;
    foreach (tx_q[k]) if (tx_q[k] !== 1'b1) zeros++;
    n_checks++; if (zeros != 0) begin n_fail++; $display("FAIL zero_txhigh got %0d low cycles exp 0", zeros); end
`endif
  endtask

  task automatic test_wrap();
    mem[14'h3FFF] = $urandom; mem[14'h0000] = $urandom;
    model(14'h3FFF, 2);
    run_dump(14'h3FFF, 15'd2, -1, -1, exp_done + 20);
    decode();
    n_checks++; if (ren_adr_q.size() != 2) begin n_fail++; $display("FAIL wrap_nren got %0d exp 2", ren_adr_q.size()); end
    for (int k = 0; k < 2 && k < ren_adr_q.size(); k++) begin
      n_checks++; if (ren_adr_q[k] !== exp_adr[k] || ren_cyc_q[k] != exp_ren[k]) begin n_fail++; $display("FAIL wrap_adr%0d got %h@%0d exp %h@%0d", k, ren_adr_q[k], ren_cyc_q[k], exp_adr[k], exp_ren[k]); end
    end
    n_checks++; if (tx_q[3+WORD_CYC] !== 1'b1 || tx_q[4+WORD_CYC] !== 1'b1 || tx_q[5+WORD_CYC] !== 1'b0) begin n_fail++; $display("FAIL wrap_gap got %b%b%b exp 110", tx_q[3+WORD_CYC], tx_q[4+WORD_CYC], tx_q[5+WORD_CYC]); end
    n_checks++; if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL wrap_nbytes got %0d exp %0d", got_b.size(), exp_b.size()); end
    for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
      n_checks++; if (got_b[k] !== exp_b[k] || got_pos[k] != exp_pos[k]) begin n_fail++; $display("FAIL wrap_byte%0d got %h@%0d exp %h@%0d", k, got_b[k], got_pos[k], exp_b[k], exp_pos[k]); end
    end
    n_checks++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL wrap_done got %0d exp %0d", done_cyc, exp_done); end
  endtask

  task automatic test_random();
    logic [ADR_W-1:0] base;
    int cnt;
    for (int it = 0; it < 3; it++) begin
      base = ADR_W'($urandom); cnt = $urandom_range(1, 2);
      for (int i = 0; i < cnt; i++) mem[ADR_W'((int'(base) + i) % (1 << ADR_W))] = $urandom;
      model(base, cnt);
      run_dump(base, 15'(cnt), -1, -1, exp_done + 20);
      decode();
      n_checks++; if (got_b.size() != exp_b.size() || hold_err != 0) begin n_fail++; $display("FAIL rand%0d_frames got %0d bytes/%0d errs exp %0d/0", it, got_b.size(), hold_err, exp_b.size()); end
      for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
        n_checks++; if (got_b[k] !== exp_b[k] || got_pos[k] != exp_pos[k]) begin n_fail++; $display("FAIL rand%0d_byte%0d got %h@%0d exp %h@%0d", it, k, got_b[k], got_pos[k], exp_b[k], exp_pos[k]); end
      end
      for (int k = 0; k < exp_adr.size() && k < ren_adr_q.size(); k++) begin
        n_checks++; if (ren_adr_q[k] !== exp_adr[k]) begin n_fail++; $display("FAIL rand%0d_adr%0d got %h exp %h", it, k, ren_adr_q[k], exp_adr[k]); end
      end
      n_checks++; if (done_cyc != exp_done || done_n != 1) begin n_fail++; $display("FAIL rand%0d_done got %0d exp %0d", it, done_cyc, exp_done); end
    end
  endtask

  task automatic test_overlap();
    mem[14'h0100] = $urandom; mem[14'h0155] = $urandom;
    model(14'h0100, 1);
    run_dump(14'h0100, 15'd1, 500, -1, exp_done + 20);
    decode();
    n_checks++; if (ren_cyc_q.size() != 1) begin n_fail++; $display("FAIL overlap_nren got %0d exp 1", ren_cyc_q.size()); end
    n_checks++; if (got_b.size() != exp_b.size()) begin n_fail++; $display("FAIL overlap_nbytes got %0d exp %0d", got_b.size(), exp_b.size()); end
    for (int k = 0; k < exp_b.size() && k < got_b.size(); k++) begin
      n_checks++; if (got_b[k] !== exp_b[k]) begin n_fail++; $display("FAIL overlap_byte%0d got %h exp %h", k, got_b[k], exp_b[k]); end
    end
    n_checks++; if (done_cyc != exp_done || done_n != 1) begin n_fail++; $display("FAIL overlap_done got %0d (x%0d) exp %0d", done_cyc, done_n, exp_done); end
  endtask

  task automatic test_abort();
    int rst_at, lows;
    rst_at = 3 + 4*CPB + 17;
    mem[14'h0200] = $urandom; mem[14'h0201] = $urandom;
    run_dump(14'h0200, 15'd2, -1, rst_at, rst_at + 60);
    n_checks++; if (tx_q[rst_at+1] !== 1'b1) begin n_fail++; $display("FAIL abort_tx got %b exp 1", tx_q[rst_at+1]); end
    n_checks++; if (busy_q[rst_at+1] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", busy_q[rst_at+1]); end
    n_checks++; if (done_n != 0) begin n_fail++; $display("FAIL abort_done got %0d pulses exp 0", done_n); end
    lows = 0;
    for (int k = rst_at + 1; k < tx_q.size(); k++) if (tx_q[k] !== 1'b1) lows++;
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL abort_idle got %0d low cycles exp 0", lows); end
  endtask

`ifdef UART_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] want [9];
    want = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFE};
    mem[14'h0020] = 32'h000000FF; mem[14'h0021] = 32'h00000001;
    run_dump(14'h0020, 15'd2, -1, -1, 3 + PERIOD + WORD_CYC + BYTE_CYC + 20);
    decode();
    n_checks++; if (got_b.size() != 9) begin n_fail++; $display("FAIL chk_nbytes got %0d exp 9", got_b.size()); end
    for (int k = 0; k < 9 && k < got_b.size(); k++) begin
      n_checks++; if (got_b[k] !== want[k]) begin n_fail++; $display("FAIL chk_byte%0d got %h exp %h", k, got_b[k], want[k]); end
    end
    n_checks++; if (done_cyc != 3 + PERIOD + WORD_CYC + BYTE_CYC) begin n_fail++; $display("FAIL chk_done got %0d exp %0d", done_cyc, 3 + PERIOD + WORD_CYC + BYTE_CYC); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_zero_count();
    test_wrap();
    test_random();
    test_overlap();
    test_abort();
`ifdef UART_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_mem_dump.md
UART_MEM_DUMP -- requirements
Module: uart_mem_dump

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 128000, meaning the serial bit rate.
REQ-003 SHALL have parameter ADR_W, default 14, meaning the memory word-address width.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a dump request, sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADR_W bits: the first word address, latched on an accepted start.
REQ-008 SHALL have port word_count, input, ADR_W+1 bits: the number of words to send, latched on an accepted start.
REQ-009 SHALL have port mem_adr, output, ADR_W bits: the word address to the synchronous RAM read port.
REQ-010 SHALL have port mem_ren, output, 1 bit: the RAM read strobe.
REQ-011 SHALL have port mem_dat, input, 32 bits: RAM read data, valid exactly one cycle after mem_ren.
REQ-012 SHALL have port tx, output, 1 bit: the serial line, which idles high.
REQ-013 SHALL have port busy, output, 1 bit: high from an accepted start until done.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-015 SHALL use CLKS_PER_BIT = CLK_HZ/BAUD with integer truncation (78 at defaults), and hold every bit for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL frame each byte as 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1); no parity.
REQ-017 SHALL send each 32-bit word as 4 bytes, least-significant byte first, with no idle time between the bytes of one word.
REQ-018 SHALL implement states IDLE, FETCH, WAIT, SEND and FIN, with transitions IDLE->FETCH on start; FETCH->WAIT; WAIT->SEND; SEND->FETCH after byte 3's stop bit if words remain, else SEND->FIN; FIN->IDLE.
REQ-019 SHALL assert mem_ren for exactly one cycle in FETCH, capture mem_dat at the end of WAIT, and drive tx low on the first SEND cycle (3 cycles after start is sampled).
REQ-020 SHALL keep tx high for the 2-cycle FETCH/WAIT gap between words.
REQ-021 SHALL compute word address i as (base_addr + i) mod 2^ADR_W, so the address wraps from 0x3FFF to 0x0000.
REQ-022 SHALL treat word_count = 0 as IDLE->FIN directly: no mem_ren, tx stays high, and done pulses on the cycle after start.
REQ-023 SHALL pulse done in the FIN cycle, with busy going low in that same cycle.
REQ-024 SHALL ignore start while busy, and SHALL NOT alter latched base_addr/word_count mid-dump.
REQ-025 SHALL hold mem_adr at its last value when mem_ren is low.

Reset
REQ-026 SHALL, on rst, set the state to IDLE, tx=1, busy=0, done=0, mem_ren=0, mem_adr=0, and clear all counters and the shift register on the next edge.
REQ-027 SHALL, on rst mid-operation, abort the frame with tx high on the next cycle and no done pulse.

Configuration
REQ-028 SHALL, with macro UART_DUMP_CHECKSUM_EN defined, send one extra byte after the last word: the XOR of all data bytes sent in this dump (0x00 when word_count = 0, in which case that byte is still sent); done follows that byte's stop bit.
REQ-029 SHALL, without UART_DUMP_CHECKSUM_EN, send no extra byte; done follows the last word's final stop bit.

Structure
REQ-030 SHALL place the state encodings, frame constants (start/stop values, bits per frame = 10, bytes per word = 4) and the CLKS_PER_BIT computation in shared package uart_dump_pkg.
REQ-031 SHALL instantiate a single sub-module, uart_tx_byte (8-bit load/valid, ready, baud counter, 10-bit shift register, tx); all sequencing SHALL stay in uart_mem_dump.

Verification
REQ-032 SHALL verify reset: rst high for 2 cycles -> tx=1, busy=0, done=0, mem_ren=0, mem_adr=0.
REQ-033 SHALL verify a single word: mem[0x0010]=0x12345678, base=0x0010, count=1, start at cycle 0 -> mem_ren at cycle 1, tx low at cycle 3, bytes 78 56 34 12, done at cycle 3123.
REQ-034 SHALL verify zero count: count=0 -> done at cycle 1, no mem_ren, tx constantly 1.
REQ-035 SHALL verify wrap: base=0x3FFF, count=2 -> mem_adr 0x3FFF then 0x0000, 8 bytes sent, 2-cycle high gap between words.
REQ-036 SHALL verify overlap and abort: a second start while busy is ignored (only the original bytes appear); rst mid-byte -> tx=1 next cycle, busy=0, no done.
REQ-037 SHALL verify the checksum with UART_DUMP_CHECKSUM_EN defined: words 0x000000FF and 0x00000001 -> bytes FF 00 00 00 01 00 00 00 FE, then done.
